cv32e41p_apu_arbiter: RTL and testbench
=======================================

Name: cv32e41p_apu_arbiter

Overview:
- Shares one APU/FPU interconnect port between NUM_REQ requesters, e.g. several core dispatchers in a cluster.
- Performs round-robin arbitration on the request channel.
- Holds the winning requester until the APU grants it.
- Records each accepted requester ID in an in-order FIFO and steers every APU response back to the requester at the FIFO head.
- Sits between the per-core APU dispatchers and the shared APU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of the opaque request payload (operands, op, flags) forwarded to the APU.
- RES_W, 32, response payload width.
- MAX_OUT, 4, maximum outstanding accepted-but-unreturned operations; ID FIFO depth (power of 2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request
- req_data_i  in  NUM_REQ x DATA_W  per-requester payload
- gnt_o  out  NUM_REQ  per-requester grant
- rvalid_o  out  NUM_REQ  per-requester response valid
- rdata_o  out  RES_W  response payload, broadcast to all requesters
- apu_req_o  out  1  request to shared APU
- apu_data_o  out  DATA_W  payload of the selected requester
- apu_gnt_i  in  1  APU grant
- apu_rvalid_i  in  1  APU response valid
- apu_rdata_i  in  RES_W  APU response payload
- busy_o  out  1  at least one operation outstanding
- err_o  out  1  sticky: a response arrived with no operation outstanding

Behaviour:
- Reset values:
  - gnt_o=0, rvalid_o=0, apu_req_o=0, busy_o=0, err_o=0.
  - FIFO empty; rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - Hold state IDLE.
- Selection:
  - When FIFO is not full and hold state is IDLE, pick the first asserted req_i searching from rr+1, wrapping modulo NUM_REQ.
  - apu_req_o = 1 when any requester is selected; apu_data_o = payload of the selected requester. Both are combinational, zero added latency.
- Grant:
  - gnt_o[sel] = apu_gnt_i & apu_req_o, same cycle.
  - A handshake is apu_req_o & apu_gnt_i.
- Hold FSM (2 states):
  - IDLE -> LOCKED when apu_req_o & !apu_gnt_i; the selected index is latched. In LOCKED the selection is forced to the latched index and the other requesters are ignored.
  - LOCKED -> IDLE on handshake.
  - If the locked requester drops req_i, this is a protocol violation: return to IDLE, with no handshake and no FIFO push.
- rr pointer: updates to the granted index only on a handshake.
- ID FIFO:
  - Pushes the granted index on a handshake.
  - Pops on apu_rvalid_i while not empty.
  - Push and pop in the same cycle are both performed; occupancy is unchanged. This is legal even when the FIFO is full, since pop frees the slot.
- Full: occupancy == MAX_OUT forces apu_req_o=0, unless a pop occurs in the same cycle.
- Responses:
  - On apu_rvalid_i with FIFO not empty: rvalid_o[head] = 1 and rdata_o = apu_rdata_i, same cycle.
  - With FIFO empty: all rvalid_o = 0 and err_o sets. err_o clears only on reset.
- The APU returns responses in acceptance order; upstream dispatchers guarantee this.
- Response at the same time as a request: both are processed independently in the same cycle.
- busy_o = FIFO not empty.
- Reset mid-operation clears all state. Any responses still outstanding at the APU then hit an empty FIFO and set err_o.

Optional Feature:
- Macro: CV32E41P_APU_ARB_PRIO_EN.
- Defined:
  - Adds input prio_i (NUM_REQ bits).
  - In IDLE, requesters with prio_i set are searched first, using round-robin among themselves. Otherwise behaviour is as without the macro.
  - The LOCKED state is never pre-empted.
- Undefined: prio_i is absent and arbitration is pure round-robin.

Decomposition:
- Package cv32e41p_apu_arb_pkg holds:
  - typedef arb_state_e {ARB_IDLE, ARB_LOCKED}.
  - Localparams for the ID width, $clog2(NUM_REQ), and the FIFO pointer width.
- Sub-module cv32e41p_apu_arb_id_fifo:
  - Synchronous FIFO with push/pop/full/empty/head.
  - Extra wrap bit on the pointers for the full/empty distinction.

Test Plan:
- Reset, then req_i=4'b1111 with apu_gnt_i=1 held for 4 cycles -> grants in order 0,1,2,3; FIFO holds 0,1,2,3; busy_o=1.
- req_i=4'b0101 with apu_gnt_i low for 3 cycles, then high -> gnt_o[0] only, in cycle 4; apu_data_o stable at req_data_i[0] throughout; requester 2 is not selected until the next cycle.
- Four accepted (IDs 2,0,3,1), then 4 apu_rvalid_i pulses with rdata 0xA..0xD -> rvalid_o to 2,0,3,1 in turn with the matching rdata; busy_o=0 after the 4th.
- FIFO full with MAX_OUT=4 and req_i[1]=1 -> apu_req_o=0. Same cycle apu_rvalid_i=1 -> pop plus push of ID 1 accepted; occupancy stays 4.
- apu_rvalid_i=1 with FIFO empty -> no rvalid_o; err_o=1 and stays set until rst_ni is asserted.
- With CV32E41P_APU_ARB_PRIO_EN: prio_i=4'b1000, req_i=4'b1011, rr=3 -> grant goes to 3 first, then 0, then 1.

Source files
------------

// File: rtl/cv32e41p_apu_arb_pkg.sv
// Shared types and defaults for the APU arbiter slice.
// Optional feature macro: CV32E41P_APU_ARB_PRIO_EN (priority-first arbitration).
package cv32e41p_apu_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned ARB_NUM_REQ = 4;
    localparam int unsigned ARB_MAX_OUT = 4;
    localparam int unsigned ARB_ID_W    = $clog2(ARB_NUM_REQ);
    localparam int unsigned ARB_PTR_W   = $clog2(ARB_MAX_OUT) + 1;

    // Index width that stays legal for a single-entry space.
    function automatic int unsigned arb_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cv32e41p_apu_arb_id_fifo.sv
// In-order requester-ID FIFO; head is a combinational read of the oldest entry.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module cv32e41p_apu_arb_id_fifo
    import cv32e41p_apu_arb_pkg::*;
#(
    parameter int unsigned DEPTH = ARB_MAX_OUT,
    parameter int unsigned WIDTH = ARB_ID_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = arb_idx_w(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/cv32e41p_apu_arbiter.sv
// Round-robin arbiter sharing one APU port among NUM_REQ requesters, with in-order response steering.
// Optional macro CV32E41P_APU_ARB_PRIO_EN adds prio_i: prioritised requesters are searched first.
module cv32e41p_apu_arbiter
    import cv32e41p_apu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RES_W   = 32,
    parameter int unsigned MAX_OUT = ARB_MAX_OUT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
`ifdef CV32E41P_APU_ARB_PRIO_EN
    input  logic [NUM_REQ-1:0]        prio_i,
`endif
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [RES_W-1:0]          rdata_o,
    output logic                      apu_req_o,
    output logic [DATA_W-1:0]         apu_data_o,
    input  logic                      apu_gnt_i,
    input  logic                      apu_rvalid_i,
    input  logic [RES_W-1:0]          apu_rdata_i,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int unsigned ID_W = arb_idx_w(NUM_REQ);
    localparam int          NR   = int'(NUM_REQ);

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   lock_idx_q, lock_idx_d;
    logic [ID_W-1:0]   rr_q, rr_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] search_mask;
    logic               rr_found;
    logic [ID_W-1:0]    rr_idx;
    logic               sel_vld;
    logic [ID_W-1:0]    sel_idx;
    logic               handshake;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [ID_W-1:0]    fifo_head;
    int                 cand;

    assign fifo_pop = apu_rvalid_i && !fifo_empty;

    always_comb begin
        search_mask = req_i;
`ifdef CV32E41P_APU_ARB_PRIO_EN
        if (|(req_i & prio_i)) begin
            search_mask = req_i & prio_i;
        end
`endif
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int off = 1; off <= NR; off++) begin
            cand = (int'(rr_q) + off) % NR;
            if (!rr_found && search_mask[cand]) begin
                rr_found = 1'b1;
                rr_idx   = ID_W'(cand);
            end
        end
    end

    // While locked only the latched requester is considered; dropping its request releases the lock.
    always_comb begin
        sel_idx = rr_idx;
        sel_vld = rr_found;
        if (state_q == ARB_LOCKED) begin
            sel_idx = lock_idx_q;
            sel_vld = req_i[lock_idx_q];
        end
    end

    assign apu_req_o  = sel_vld && (!fifo_full || fifo_pop);
    assign apu_data_o = req_data_i[int'(sel_idx)*int'(DATA_W) +: DATA_W];
    assign handshake  = apu_req_o && apu_gnt_i;

    always_comb begin
        gnt_o = '0;
        if (handshake) begin
            gnt_o[sel_idx] = 1'b1;
        end
        rvalid_o = '0;
        if (fifo_pop) begin
            rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign rdata_o = apu_rdata_i;
    assign busy_o  = !fifo_empty;
    assign err_o   = err_q;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_d       = rr_q;
        err_d      = err_q || (apu_rvalid_i && fifo_empty);
        if (handshake) begin
            rr_d = sel_idx;
        end
        case (state_q)
            ARB_IDLE: begin
                if (apu_req_o && !apu_gnt_i) begin
                    state_d    = ARB_LOCKED;
                    lock_idx_d = sel_idx;
                end
            end
            ARB_LOCKED: begin
                if (!sel_vld || handshake) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
            rr_q       <= ID_W'(NUM_REQ - 1);
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_q       <= rr_d;
            err_q      <= err_d;
        end
    end

    cv32e41p_apu_arb_id_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (sel_idx),
        .pop_i   (apu_rvalid_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_cv32e41p_apu_arbiter.sv
// Directed bench for cv32e41p_apu_arbiter: arbitration order, hold, in-order responses, full and error cases.
module tb_cv32e41p_apu_arbiter;

    logic         clk_i;
    logic         rst_ni;
    logic [3:0]   req_i;
    logic [127:0] req_data_i;
`ifdef CV32E41P_APU_ARB_PRIO_EN
    logic [3:0]   prio_i;
`endif
    logic [3:0]   gnt_o;
    logic [3:0]   rvalid_o;
    logic [31:0]  rdata_o;
    logic         apu_req_o;
    logic [31:0]  apu_data_o;
    logic         apu_gnt_i;
    logic         apu_rvalid_i;
    logic [31:0]  apu_rdata_i;
    logic         busy_o;
    logic         err_o;

    int n_checks = 0;
    int n_errors = 0;

    cv32e41p_apu_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .req_data_i   (req_data_i),
`ifdef CV32E41P_APU_ARB_PRIO_EN
        .prio_i       (prio_i),
`endif
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .apu_req_o    (apu_req_o),
        .apu_data_o   (apu_data_o),
        .apu_gnt_i    (apu_gnt_i),
        .apu_rvalid_i (apu_rvalid_i),
        .apu_rdata_i  (apu_rdata_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [3:0] exp_gnt [4];
        logic [3:0] exp_rv  [4];

        rst_ni       = 1'b0;
        req_i        = '0;
        apu_gnt_i    = 1'b0;
        apu_rvalid_i = 1'b0;
        apu_rdata_i  = '0;
`ifdef CV32E41P_APU_ARB_PRIO_EN
        prio_i       = '0;
`endif
        for (int i = 0; i < 4; i++) req_data_i[i*32 +: 32] = 32'h100 + i;
        #12;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_apu_req", apu_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

        // All four requesting with grant held: round-robin 0,1,2,3.
        req_i = 4'b1111; apu_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_gnt", gnt_o, 4'b1 << k);
            chk("rr_data", apu_data_o, 32'h100 + k);
            tick();
        end
        settle();
        chk("rr_busy", busy_o, 1);
        chk("rr_full_noreq", apu_req_o, 0);
        req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apu_rdata_i = 32'h10 + k;
            settle();
            chk("drain1_rvalid", rvalid_o, 4'b1 << k);
            chk("drain1_rdata", rdata_o, 32'h10 + k);
            tick();
        end
        apu_rvalid_i = 1'b0;
        settle();
        chk("drain1_busy", busy_o, 0);

        // Hold: requester 0 locked while the APU stalls, 2 waits.
        req_i = 4'b0101; apu_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("hold_req", apu_req_o, 1);
            chk("hold_gnt", gnt_o, 0);
            chk("hold_data", apu_data_o, 32'h100);
            tick();
        end
        apu_gnt_i = 1'b1;
        settle();
        chk("hold_gnt4", gnt_o, 4'b0001);
        chk("hold_data4", apu_data_o, 32'h100);
        tick();
        settle();
        chk("hold_next", gnt_o, 4'b0100);
        chk("hold_next_data", apu_data_o, 32'h102);
        tick();
        req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
        settle();
        chk("drain2_a", rvalid_o, 4'b0001);
        tick();
        settle();
        chk("drain2_b", rvalid_o, 4'b0100);
        tick();
        apu_rvalid_i = 1'b0;

        // Accept IDs 2,0,3,1, then return A..D in order.
        exp_gnt[0] = 4'b0100; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b1000; exp_gnt[3] = 4'b0010;
        apu_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_i = exp_gnt[k];
            settle();
            chk("seq_gnt", gnt_o, exp_gnt[k]);
            tick();
        end
        req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apu_rdata_i = 32'hA + k;
            settle();
            chk("seq_rvalid", rvalid_o, exp_gnt[k]);
            chk("seq_rdata", rdata_o, 32'hA + k);
            tick();
        end
        apu_rvalid_i = 1'b0;
        settle();
        chk("seq_busy", busy_o, 0);

        // Fill (rr=1 -> 2,3,0,1), then push-with-pop while full.
        exp_gnt[0] = 4'b0100; exp_gnt[1] = 4'b1000; exp_gnt[2] = 4'b0001; exp_gnt[3] = 4'b0010;
        req_i = 4'b1111; apu_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("fill_gnt", gnt_o, exp_gnt[k]);
            tick();
        end
        req_i = 4'b0010;
        settle();
        chk("full_apu_req", apu_req_o, 0);
        chk("full_gnt", gnt_o, 0);
        apu_rvalid_i = 1'b1; apu_rdata_i = 32'hE;
        settle();
        chk("full_pop_req", apu_req_o, 1);
        chk("full_pop_gnt", gnt_o, 4'b0010);
        chk("full_pop_rvalid", rvalid_o, 4'b0100);
        tick();
        apu_rvalid_i = 1'b0;
        settle();
        chk("full_still", apu_req_o, 0);
        chk("full_busy", busy_o, 1);
        exp_rv[0] = 4'b1000; exp_rv[1] = 4'b0001; exp_rv[2] = 4'b0010; exp_rv[3] = 4'b0010;
        req_i = '0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("drain3_rvalid", rvalid_o, exp_rv[k]);
            tick();
        end
        apu_rvalid_i = 1'b0;
        settle();
        chk("drain3_busy", busy_o, 0);
        chk("no_err_yet", err_o, 0);

        // Response with nothing outstanding: sticky error.
        apu_rvalid_i = 1'b1;
        settle();
        chk("empty_rvalid", rvalid_o, 0);
        tick();
        apu_rvalid_i = 1'b0;
        settle();
        chk("err_set", err_o, 1);
        tick();
        tick();
        chk("err_sticky", err_o, 1);
        rst_ni = 1'b0;
        settle();
        chk("err_cleared", err_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();

`ifdef CV32E41P_APU_ARB_PRIO_EN
        exp_gnt[0] = 4'b1000; exp_gnt[1] = 4'b0001; exp_gnt[2] = 4'b0010;
        prio_i = 4'b1000; apu_gnt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_i = 4'b1011 & ~(k > 0 ? 4'b1000 : 4'b0000) & ~(k > 1 ? 4'b0001 : 4'b0000);
            settle();
            chk("prio_gnt", gnt_o, exp_gnt[k]);
            tick();
        end
`else
        req_i = 4'b1111; apu_gnt_i = 1'b1;
        settle();
        chk("post_rst_gnt", gnt_o, 4'b0001);
        tick();
`endif
        req_i = '0; apu_gnt_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
